// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared types for the core-to-memory bus bridge
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bus_state_e;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    // Low byte of the reset vector; the first access after reset
    localparam addr_t RESET_VEC_LO = 16'hFFFC;

endpackage

// File: rtl/bus_timeout_ctr.sv
// rtl/bus_timeout_ctr.sv - clearable cycle counter flagging TIMEOUT-1 elapsed cycles
module bus_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Count enabled cycles since the last clear; hold once the limit is reached
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/cpu_mem_bridge.sv
// rtl/cpu_mem_bridge.sv - synchronous-memory core port to req/ack bus with stall and timeout
module cpu_mem_bridge
    import cpu_bus_pkg::*;
#(
    parameter int         TIMEOUT      = 64,
    parameter logic [7:0] TIMEOUT_DATA = 8'hFF,
    parameter bit         POSTED_WR    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    output logic [7:0]  cpu_di,
    output logic        cpu_rdy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        bus_err,
    output logic [15:0] err_addr
);

    bus_state_e state, state_nxt;
    logic       expired;
    logic       ack_seen;
    logic       timed_out;

    // Both outputs decode straight from the state register, so reset
    // drops the request and releases the core without waiting for a clock.
    assign cpu_rdy   = (state != BUSY);
    assign mem_req   = (state == BUSY);
    assign ack_seen  = mem_req && mem_ack;
    assign timed_out = mem_req && expired && !mem_ack;

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (cpu_rdy),
        .en      (mem_req),
        .expired (expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: every ready cycle captures an access, BUSY ends on ack or timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = BUSY;
            BUSY:    if (ack_seen || timed_out) state_nxt = DONE;
            DONE:    state_nxt = BUSY;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the core's access on every ready edge; held for the whole request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (cpu_rdy) begin
            mem_addr  <= addr_t'(cpu_ab);
            mem_we    <= cpu_we;
            mem_wdata <= data_t'(cpu_do);
        end
    end

    // Return data to the core; only completions change it, so it is stable while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_di <= '0;
        end else if (ack_seen || timed_out) begin
            if (!mem_we) begin
                cpu_di <= ack_seen ? mem_rdata : TIMEOUT_DATA;
            end else if (!POSTED_WR) begin
                cpu_di <= mem_wdata;
            end
        end
    end

    // Sticky error flag; the address is kept from the first timeout only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err  <= 1'b0;
            err_addr <= '0;
        end else if (timed_out) begin
            bus_err <= 1'b1;
            if (!bus_err) begin
                err_addr <= mem_addr;
            end
        end
    end

endmodule
